// File: rtl/prog_loader.sv
// prog_loader: packs a little-endian boot byte stream into 32-bit words,
// writes them to the instruction cache, then enables the CPU.
module prog_loader #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_wen,
    output logic              enable,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   byte_count
);

    typedef enum logic [2:0] {IDLE, RECV, WRITE, RUN, ERR} state_t;

    localparam logic [ADDR_W-1:0] WSTEP     = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] LAST_WORD = {{(ADDR_W-2){1'b1}}, 2'b00};

    state_t              state_q, state_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [31:0]         lanes_q, lanes_d;
    logic                last_q, last_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                s_ready_q, s_ready_d;
    logic                mem_wen_q, mem_wen_d;
    logic                enable_q, enable_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        waddr_d     = waddr_q;
        lanes_d     = lanes_q;
        last_d      = last_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            IDLE, RUN, ERR: begin
                if (start) begin
                    state_d = RECV;
                    cnt_d   = '0;
                    waddr_d = '0;
                    lanes_d = '0;
                    last_d  = 1'b0;
                end
            end
            RECV: begin
                if (s_valid && s_ready_q) begin
                    lanes_d[{cnt_q[1:0], 3'b000} +: 8] = s_data;
                    cnt_d  = cnt_q + 1'b1;
                    last_d = s_last;
                    if (cnt_q[1:0] == 2'd3 || s_last) begin
                        state_d     = WRITE;
                        mem_addr_d  = waddr_q;
                        mem_wdata_d = lanes_d;
                    end
                end
            end
            WRITE: begin
                waddr_d = waddr_q + WSTEP;
                lanes_d = '0;
                if (last_q)
                    state_d = RUN;
                else if (waddr_q == LAST_WORD)
                    state_d = ERR;
                else
                    state_d = RECV;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they register cleanly.
        s_ready_d = (state_d == RECV);
        mem_wen_d = (state_d == WRITE);
        busy_d    = (state_d == RECV) || (state_d == WRITE);
        enable_d  = (state_d == RUN);
        done_d    = (state_d == RUN);
        err_d     = (state_d == ERR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            waddr_q     <= '0;
            lanes_q     <= '0;
            last_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            s_ready_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
            enable_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            waddr_q     <= waddr_d;
            lanes_q     <= lanes_d;
            last_q      <= last_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            s_ready_q   <= s_ready_d;
            mem_wen_q   <= mem_wen_d;
            enable_q    <= enable_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wen    = mem_wen_q;
    assign enable     = enable_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign byte_count = cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed bench for prog_loader with a 16-byte memory
// so the overflow boundary is reachable.
module tb_prog_loader;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    s_data = 8'h00;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_wen;
    logic          enable;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   byte_count;

    int errors = 0;
    int checks = 0;

    logic [7:0]    img [0:31];
    logic [AW-1:0] wa [$];
    logic [31:0]   wd [$];
    time           wt [$];
    time           at [$];
    int            bad_ready = 0;

    prog_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wen(mem_wen), .enable(enable), .busy(busy), .done(done),
        .err(err), .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_wen) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
            wt.push_back($time);
            if (s_ready) bad_ready++;
        end
    end

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wt.delete();
        bad_ready = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input int n, input bit use_last, input bit gaps,
                        input int budget, output int acc);
        int cyc = 0;
        acc = 0;
        at.delete();
        s_valid = 1'b0;
        while (acc < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (!s_valid && (!gaps || $urandom_range(0, 2) != 0)) begin
                s_valid = 1'b1;
                s_data  = img[acc];
                s_last  = use_last && (acc == n - 1);
            end
            if (s_valid && s_ready) begin
                @(posedge clk);
                #1;
                at.push_back($time);
                acc++;
                s_valid = 1'b0;
                s_last  = 1'b0;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            start   = 1'($urandom);
            s_valid = 1'($urandom);
            s_last  = 1'($urandom);
            s_data  = 8'($urandom);
        end
        @(negedge clk);
        checks++;
        if ({s_ready, mem_wen, enable, busy, done, err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000000",
                     {s_ready, mem_wen, enable, busy, done, err});
        end
        checks++;
        if (byte_count !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_regs: cnt=%0d addr=%0d data=%h want 0",
                     byte_count, mem_addr, mem_wdata);
        end
        start = 1'b0;
        rst   = 1'b1;
        repeat (3) begin
            @(negedge clk);
            s_valid = 1'($urandom);
            s_data  = 8'($urandom);
        end
        @(negedge clk);
        s_valid = 1'b0;
        checks++;
        if (s_ready !== 1'b0 || busy !== 1'b0 || mem_wen !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: ready=%b busy=%b wen=%b want 0",
                     s_ready, busy, mem_wen);
        end
    endtask

    task automatic test_full();
        int acc;
        for (int i = 0; i < 8; i++) img[i] = 8'(i + 1);
        clear_log();
        pulse_start();
        send(8, 1'b1, 1'b0, 100, acc);
        @(negedge clk);
        checks++;
        if (enable !== 1'b0) begin
            errors++;
            $display("FAIL full_enable_early: got %b want 0", enable);
        end
        @(negedge clk);
        checks++;
        if (acc !== 8 || enable !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL full_run: acc=%0d en=%b done=%b want 8 1 1",
                     acc, enable, done);
        end
        checks++;
        if (byte_count !== 5'd8) begin
            errors++;
            $display("FAIL full_count: got %0d want 8", byte_count);
        end
        checks++;
        if (wa.size() !== 2) begin
            errors++;
            $display("FAIL full_nwrites: got %0d want 2", wa.size());
        end else begin
            checks++;
            if (wa[0] !== 4'd0 || wd[0] !== 32'h04030201) begin
                errors++;
                $display("FAIL full_w0: got %0d/%h want 0/04030201",
                         wa[0], wd[0]);
            end
            checks++;
            if (wa[1] !== 4'd4 || wd[1] !== 32'h08070605) begin
                errors++;
                $display("FAIL full_w1: got %0d/%h want 4/08070605",
                         wa[1], wd[1]);
            end
            checks++;
            if (wt[0] - at[3] !== 4) begin
                errors++;
                $display("FAIL full_latency: got %0t want 4", wt[0] - at[3]);
            end
            checks++;
            if (at[7] - at[3] !== 50) begin
                errors++;
                $display("FAIL full_rate: got %0t want 50", at[7] - at[3]);
            end
        end
    endtask

    task automatic test_partial();
        int acc;
        for (int i = 0; i < 6; i++) img[i] = 8'(8'hAA + i);
        clear_log();
        pulse_start();
        send(6, 1'b1, 1'b0, 100, acc);
        repeat (2) @(negedge clk);
        checks++;
        if (enable !== 1'b1 || byte_count !== 5'd6) begin
            errors++;
            $display("FAIL part_run: en=%b cnt=%0d want 1 6",
                     enable, byte_count);
        end
        checks++;
        if (wa.size() !== 2) begin
            errors++;
            $display("FAIL part_nwrites: got %0d want 2", wa.size());
        end else begin
            checks++;
            if (wa[0] !== 4'd0 || wd[0] !== 32'hADACABAA) begin
                errors++;
                $display("FAIL part_w0: got %0d/%h want 0/adacabaa",
                         wa[0], wd[0]);
            end
            checks++;
            if (wa[1] !== 4'd4 || wd[1] !== 32'h0000AFAE) begin
                errors++;
                $display("FAIL part_w1: got %0d/%h want 4/0000afae",
                         wa[1], wd[1]);
            end
        end
    endtask

    task automatic test_gaps();
        int acc;
        for (int i = 0; i < 8; i++) img[i] = 8'(i + 1);
        clear_log();
        pulse_start();
        send(8, 1'b1, 1'b1, 300, acc);
        repeat (2) @(negedge clk);
        checks++;
        if (acc !== 8 || enable !== 1'b1 || byte_count !== 5'd8) begin
            errors++;
            $display("FAIL gaps_run: acc=%0d en=%b cnt=%0d want 8 1 8",
                     acc, enable, byte_count);
        end
        checks++;
        if (bad_ready !== 0) begin
            errors++;
            $display("FAIL gaps_ready_on_write: got %0d want 0", bad_ready);
        end
        checks++;
        if (wa.size() !== 2) begin
            errors++;
            $display("FAIL gaps_nwrites: got %0d want 2", wa.size());
        end else begin
            checks++;
            if (wa[0] !== 4'd0 || wd[0] !== 32'h04030201 ||
                wa[1] !== 4'd4 || wd[1] !== 32'h08070605) begin
                errors++;
                $display("FAIL gaps_data: got %0d/%h %0d/%h",
                         wa[0], wd[0], wa[1], wd[1]);
            end
        end
    endtask

    task automatic test_overflow();
        int acc;
        logic [31:0] exp_w;
        for (int i = 0; i < 17; i++) img[i] = 8'(8'h20 + i);
        clear_log();
        pulse_start();
        send(17, 1'b0, 1'b0, 40, acc);
        @(negedge clk);
        checks++;
        if (acc !== 16) begin
            errors++;
            $display("FAIL ovf_accepted: got %0d want 16", acc);
        end
        checks++;
        if (err !== 1'b1 || s_ready !== 1'b0 || enable !== 1'b0 ||
            busy !== 1'b0) begin
            errors++;
            $display("FAIL ovf_flags: err=%b rdy=%b en=%b busy=%b want 1000",
                     err, s_ready, enable, busy);
        end
        checks++;
        if (byte_count !== 5'd16) begin
            errors++;
            $display("FAIL ovf_count: got %0d want 16", byte_count);
        end
        checks++;
        if (wa.size() !== 4) begin
            errors++;
            $display("FAIL ovf_nwrites: got %0d want 4", wa.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                exp_w = {img[4*k+3], img[4*k+2], img[4*k+1], img[4*k]};
                checks++;
                if (wa[k] !== AW'(4 * k) || wd[k] !== exp_w) begin
                    errors++;
                    $display("FAIL ovf_w%0d: got %0d/%h want %0d/%h",
                             k, wa[k], wd[k], 4 * k, exp_w);
                end
            end
        end
        for (int i = 0; i < 8; i++) img[i] = 8'(i + 1);
        clear_log();
        pulse_start();
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ovf_restart: err=%b busy=%b want 0 1", err, busy);
        end
        send(8, 1'b1, 1'b0, 100, acc);
        repeat (2) @(negedge clk);
        checks++;
        if (enable !== 1'b1 || wa.size() !== 2) begin
            errors++;
            $display("FAIL ovf_reload: en=%b writes=%0d want 1 2",
                     enable, wa.size());
        end else begin
            checks++;
            if (wd[0] !== 32'h04030201 || wd[1] !== 32'h08070605) begin
                errors++;
                $display("FAIL ovf_reload_data: got %h %h", wd[0], wd[1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        int n0;
        for (int i = 0; i < 8; i++) img[i] = 8'(8'h40 + i);
        clear_log();
        pulse_start();
        send(5, 1'b0, 1'b0, 100, acc);
        n0 = wa.size();
        rst     = 1'b0;
        s_valid = 1'b1;
        s_last  = 1'b1;
        s_data  = 8'h55;
        #1;
        checks++;
        if (n0 !== 1 || s_ready !== 1'b0 || busy !== 1'b0 ||
            byte_count !== '0) begin
            errors++;
            $display("FAIL mid_async: n0=%0d rdy=%b busy=%b cnt=%0d",
                     n0, s_ready, busy, byte_count);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        checks++;
        if (wa.size() !== n0 || enable !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_quiet: writes=%0d en=%b busy=%b want %0d 0 0",
                     wa.size(), enable, busy, n0);
        end
    endtask

    task automatic test_reload_run();
        int acc;
        for (int i = 0; i < 8; i++) img[i] = 8'(i + 1);
        clear_log();
        pulse_start();
        send(8, 1'b1, 1'b0, 100, acc);
        repeat (2) @(negedge clk);
        checks++;
        if (enable !== 1'b1) begin
            errors++;
            $display("FAIL rerun_first: en=%b want 1", enable);
        end
        for (int i = 0; i < 8; i++) img[i] = 8'(8'h11 + i);
        clear_log();
        pulse_start();
        checks++;
        if (enable !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rerun_drop: en=%b done=%b busy=%b want 0 0 1",
                     enable, done, busy);
        end
        send(8, 1'b1, 1'b0, 100, acc);
        repeat (2) @(negedge clk);
        checks++;
        if (enable !== 1'b1 || wa.size() !== 2) begin
            errors++;
            $display("FAIL rerun_done: en=%b writes=%0d want 1 2",
                     enable, wa.size());
        end else begin
            checks++;
            if (wa[0] !== 4'd0 || wd[0] !== 32'h14131211 ||
                wa[1] !== 4'd4 || wd[1] !== 32'h18171615) begin
                errors++;
                $display("FAIL rerun_data: got %0d/%h %0d/%h",
                         wa[0], wd[0], wa[1], wd[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full();
        test_partial();
        test_gaps();
        test_overflow();
        test_reset_mid();
        test_reload_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time program loader sitting directly upstream of the CPU `control` block.
- Accepts the program image as a byte stream (file byte order, little-endian words) and packs every 4 bytes into one 32-bit word.
- Writes each word into the instruction cache through a word write port, in the cache's big-endian byte-lane order.
- When the image is complete, raises `enable` to start `control`. This replaces hierarchical memory pokes from benches.

Parameters:
- ADDR_W, 12, byte-address width of the instruction memory; capacity is 2^ADDR_W bytes.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load.
- s_data  in  8  stream byte.
- s_valid  in  1  s_data is valid.
- s_last  in  1  marks the final byte of the image; qualified by s_valid.
- s_ready  out  1  loader accepts a byte this cycle.
- mem_addr  out  ADDR_W  byte address of the word being written; always a multiple of 4.
- mem_wdata  out  32  word as {bank[a],bank[a+1],bank[a+2],bank[a+3]} = {b3,b2,b1,b0}.
- mem_wen  out  1  one-cycle word write strobe.
- enable  out  1  run enable to `control`.
- busy  out  1  load in progress.
- done  out  1  load finished; CPU running.
- err  out  1  image overflowed capacity.
- byte_count  out  ADDR_W+1  bytes accepted in the current or last load.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - All outputs 0, including s_ready, mem_wen, enable, done, err, byte_count, mem_addr and mem_wdata.
  - Lane registers cleared.
  - Reset mid-load abandons the load; no further writes occur.
- Byte transfer occurs on a rising edge with s_valid=1 and s_ready=1. The producer holds s_data and s_last stable while s_ready=0.
- States: IDLE, RECV, WRITE, RUN, ERR.
- IDLE:
  - s_ready=0.
  - start=1 → RECV; byte_count=0, word address=0, lanes=0, err=0.
- RECV:
  - s_ready=1.
  - An accepted byte goes into lane k = byte_count[1:0], where lane0 = b0 (LSB of wdata).
  - byte_count is incremented.
  - → WRITE if k==3 or s_last=1. With s_last on a partial word, unfilled lanes stay 0 (zero-padded high bytes).
- WRITE (exactly 1 cycle):
  - s_ready=0, mem_wen=1, mem_addr=current word address, mem_wdata={lane3,lane2,lane1,lane0}.
  - Next state:
    - If last was seen → RUN.
    - Else if word address == 2^ADDR_W−4 → ERR.
    - Else → RECV.
  - In every case: word address += 4, lanes cleared.
- RUN:
  - enable=1 and done=1, both registered; first high the cycle after the WRITE cycle.
  - s_ready=0.
  - start=1 → enable=0 and done=0 the next cycle; restart as from IDLE (reload).
- ERR:
  - err=1, enable=0, s_ready=0.
  - Leaves only by reset or start (which restarts the load).
- busy=1 in RECV and WRITE only.
- start is ignored in RECV and WRITE.
- Latency:
  - 4th byte accepted at edge N → mem_wen high between edges N and N+1.
  - Sustained throughput is 4 bytes per 5 cycles.
- byte_count saturates naturally at 2^ADDR_W; it is held after completion for inspection until the next start.
- No write is ever issued at an address ≥ 2^ADDR_W.

Test Plan:
- Reset: hold rst=0 with random inputs → all outputs 0; release, no start → state stays IDLE, s_ready=0.
- Full-word load: start, then stream 0x01..0x08 with s_last on 0x08 →
  - write addr 0, data 0x04030201;
  - write addr 4, data 0x08070605;
  - enable=1 one cycle after the 2nd write;
  - byte_count=8, done=1.
- Partial word: stream 0xAA..0xAF, s_last on 0xAF → addr 0 = 0xADACABAA, addr 4 = 0x0000AFAE, enable=1.
- Backpressure/gaps: random s_valid gaps during an 8-byte load → s_ready=0 on each WRITE cycle, no byte dropped or duplicated, same data as the full-word case.
- Overflow (ADDR_W=4): 17 bytes, no s_last →
  - 4 writes at addresses 0, 4, 8, 12;
  - err=1, s_ready=0, enable=0, byte_count=16.
  - Then start → err=0 and reload succeeds.
- Reset mid-load and reload: assert rst after 5 bytes → no further mem_wen. After a completed load, start while in RUN → enable drops next cycle, new image written from addr 0.
